dcache_data_array: RTL and testbench
====================================

# dcache_data_array

Parametrised N-way data array for the data cache. It replaces the single fixed 512x32 byte-enabled SRAM with WAYS independent byte-enabled banks behind one clock. It adds four things the single SRAM lacks:
- a self-clearing sequencer after reset;
- write-first forwarding on same-address read/write collisions;
- late way selection by the cache hit vector;
- an optional output register stage.

It sits between the cache controller (tag compare, fill/evict) and the load/store data path.

## Interface
- WAYS, 4: number of ways/banks, 1..8
- ADDR_WIDTH, 9: set index width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32: line-word width
- BYTE_SIZE, 8: bits per byte lane, 8 or 9; DATA_WIDTH must be a multiple
- OUTPUT_REG, 0: 1 adds one output register stage
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous and active-high
- init_busy  out  1  high while the clear sequencer runs; accesses ignored
- wr_en  in  1  write strobe
- wr_way  in  WAYS  one-hot (or multi-hot) target ways
- wr_addr  in  ADDR_WIDTH  write set index
- wr_byte_en  in  DATA_WIDTH/BYTE_SIZE  per-lane write enable
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read strobe, all ways read in parallel
- rd_addr  in  ADDR_WIDTH  read set index
- rd_sel  in  WAYS  hit vector, sampled the cycle after rd_en
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_WIDTH  selected way data

## Operation
- FSM states: CLEAR and READY.
- rst high: state CLEAR, clear address = 0. Reset values: init_busy=1, rd_valid=0, rd_data=0.
- CLEAR:
  - Each cycle, write all-zero data with all byte lanes enabled to every way at the clear address, then increment the address.
  - At address 2**ADDR_WIDTH-1, move to READY.
  - wr_en and rd_en are ignored; rd_valid stays 0.
- READY:
  - A write updates only the lanes set in wr_byte_en, in every way set in wr_way.
  - wr_byte_en=0 or wr_way=0: no change.
- Read data = bitwise OR of the way outputs masked by rd_sel.
  - rd_sel=0 gives data 0 with rd_valid still 1.
  - Multi-hot rd_sel ORs the selected ways; this is a controller error, but the behaviour is defined.
- Collision: wr_en and rd_en in the same cycle, same address, READY.
  - Read returns the new value: written lanes come from wr_data for ways in wr_way; other lanes and other ways return old contents.
  - The banks are not relied on for this. A registered bypass (addr match, byte_en, way, data) is merged at the output.
- Reset mid-operation, in either state: abort, restart CLEAR at address 0, drop any in-flight read (rd_valid=0 the next cycle).
- Widths: BE_WIDTH = DATA_WIDTH/BYTE_SIZE. The clear address counter is ADDR_WIDTH+1 bits so the terminal count is unambiguous.

## Timing
- After rst deasserts, init_busy is high for exactly 2**ADDR_WIDTH cycles. It falls on the edge that writes the last address.
- Read latency:
  - OUTPUT_REG=0: rd_en at edge N gives rd_valid/rd_data at N+1; rd_sel is applied combinationally during the cycle after N.
  - OUTPUT_REG=1: rd_sel is still sampled in the cycle after N, the muxed result is registered, and rd_valid/rd_data appear at N+2.
- Write at edge N, read of the same address issued at edge N+1: returns the new data (no hazard).
- Throughput: one read and one write per cycle, back-to-back, no stalls once READY.
- rd_valid is a single-cycle pulse per accepted rd_en. rd_data holds its last value when rd_valid=0; it is 0 after reset.

## Structure
- Shared package dcache_pkg holds:
  - the state enum (CLEAR, READY);
  - a be_width(DATA_WIDTH, BYTE_SIZE) function;
  - the default WAYS/ADDR_WIDTH/DATA_WIDTH constants shared with the tag array.
- Sub-module dcache_sdp_bank: one way, simple dual-port, byte-enabled, 1-cycle read, read-during-write undefined. It is instantiated WAYS times via generate.
- The top level holds the clear FSM, write mux (clear vs. user), collision bypass, way mux and optional output register.

## Test plan
- Clear: assert rst 1 cycle, then check init_busy is high for 512 cycles. Then read all 4 ways at addresses 0, 255 and 511 with rd_sel=0001/0010/0100/1000; every read returns 0x00000000.
- Byte enables: write way 2, addr 0x05, data 0xAABBCCDD, be=1111. Then write 0x11223344 with be=0101. Read with rd_sel=0100; expect 0xAA22CC44.
- Way isolation/late select: write 0x0000_000k to way k at addr 0x10 for k=0..3. Read once, then drive rd_sel=1000 on the next cycle; expect 0x00000003. With rd_sel=0000, expect 0 with rd_valid=1.
- Collision: addr 0x20 holds 0x12345678 in way 1. In the same cycle, write 0xFFFF0000 with be=1100 and read addr 0x20 with rd_sel=0010; expect 0xFFFF5678. Repeat with OUTPUT_REG=1 and check the result appears one cycle later.
- Reset mid-operation: assert rst at clear address 300 and check CLEAR restarts with a full 512-cycle init_busy. Also assert rst while a read is in flight in READY and check no rd_valid pulse follows.
- Accesses during CLEAR: drive wr_en/rd_en with data 0xDEADBEEF while init_busy=1. Expect no rd_valid, and memory still 0 after READY.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared data-cache definitions: sequencer states, byte-lane helper and the
// default geometry also used by the tag array.
package dcache_pkg;

    localparam int DEF_WAYS       = 4;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic int be_width(input int data_width, input int byte_size);
        return data_width / byte_size;
    endfunction

endpackage

// File: rtl/dcache_sdp_bank.sv
// One way of the data array: simple dual-port, byte-enabled, registered read.
// Read-during-write to the same address returns the old word; the top level fixes that up.
module dcache_sdp_bank
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BYTE_SIZE  = 8
) (
    input  logic                                    i_clk,
    input  logic                                    i_wr_en,
    input  logic [ADDR_WIDTH-1:0]                   i_wr_addr,
    input  logic [be_width(DATA_WIDTH, BYTE_SIZE)-1:0] i_wr_be,
    input  logic [DATA_WIDTH-1:0]                   i_wr_data,
    input  logic                                    i_rd_en,
    input  logic [ADDR_WIDTH-1:0]                   i_rd_addr,
    output logic [DATA_WIDTH-1:0]                   o_rd_data
);

    localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);
    localparam int DEPTH    = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_addr][b*BYTE_SIZE +: BYTE_SIZE] <= i_wr_data[b*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dcache_data_array.sv
// N-way byte-enabled data array with post-reset clear, write-first collision
// bypass, late way select by hit vector and an optional output register.
//
// state | meaning
// CLEAR | zeroing every way, one set per cycle; user accesses ignored
// READY | normal service, one read and one write per cycle
module dcache_data_array
    import dcache_pkg::*;
#(
    parameter int WAYS       = DEF_WAYS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BYTE_SIZE  = 8,
    parameter int OUTPUT_REG = 0
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    output logic                                       o_init_busy,
    input  logic                                       i_wr_en,
    input  logic [WAYS-1:0]                            i_wr_way,
    input  logic [ADDR_WIDTH-1:0]                      i_wr_addr,
    input  logic [be_width(DATA_WIDTH, BYTE_SIZE)-1:0] i_wr_byte_en,
    input  logic [DATA_WIDTH-1:0]                      i_wr_data,
    input  logic                                       i_rd_en,
    input  logic [ADDR_WIDTH-1:0]                      i_rd_addr,
    input  logic [WAYS-1:0]                            i_rd_sel,
    output logic                                       o_rd_valid,
    output logic [DATA_WIDTH-1:0]                      o_rd_data
);

    localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);
    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_clr_addr;
    logic                  r_init_busy;

    logic                  r_rd_pend;
    logic                  r_byp_valid;
    logic [WAYS-1:0]       r_byp_way;
    logic [BE_WIDTH-1:0]   r_byp_be;
    logic [DATA_WIDTH-1:0] r_byp_data;

    logic                  w_clearing;
    logic                  w_rd_acc;
    logic [WAYS-1:0]       w_bank_we;
    logic [ADDR_WIDTH-1:0] w_bank_addr;
    logic [BE_WIDTH-1:0]   w_bank_be;
    logic [DATA_WIDTH-1:0] w_bank_wdata;
    logic [DATA_WIDTH-1:0] w_bank_rd [WAYS];
    logic [DATA_WIDTH-1:0] w_way_data [WAYS];
    logic [DATA_WIDTH-1:0] w_mux;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_CLEAR;
            r_clr_addr  <= '0;
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == CLR_LAST) begin
                        r_state     <= ST_READY;
                        r_init_busy <= 1'b0;
                    end
                end
                default: r_state <= ST_READY;
            endcase
        end
    end

    assign o_init_busy = r_init_busy;
    assign w_clearing  = (r_state == ST_CLEAR);
    assign w_rd_acc    = i_rd_en && !w_clearing;

    // Clear sequencer owns the write port of every bank until READY.
    assign w_bank_we    = w_clearing ? {WAYS{1'b1}} : (i_wr_en ? i_wr_way : '0);
    assign w_bank_addr  = w_clearing ? r_clr_addr[ADDR_WIDTH-1:0] : i_wr_addr;
    assign w_bank_be    = w_clearing ? {BE_WIDTH{1'b1}} : i_wr_byte_en;
    assign w_bank_wdata = w_clearing ? '0 : i_wr_data;

    for (genvar g = 0; g < WAYS; g++) begin : g_bank
        dcache_sdp_bank #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .BYTE_SIZE  (BYTE_SIZE)
        ) u_bank (
            .i_clk     (i_clk),
            .i_wr_en   (w_bank_we[g]),
            .i_wr_addr (w_bank_addr),
            .i_wr_be   (w_bank_be),
            .i_wr_data (w_bank_wdata),
            .i_rd_en   (w_rd_acc),
            .i_rd_addr (i_rd_addr),
            .o_rd_data (w_bank_rd[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_pend   <= 1'b0;
            r_byp_valid <= 1'b0;
        end else begin
            r_rd_pend   <= w_rd_acc;
            r_byp_valid <= w_rd_acc && i_wr_en && (i_wr_addr == i_rd_addr);
        end
    end

    always_ff @(posedge i_clk) begin
        r_byp_way  <= i_wr_way;
        r_byp_be   <= i_wr_byte_en;
        r_byp_data <= i_wr_data;
    end

    // Same-cycle write lanes override the (stale) bank word, then the hit vector selects.
    always_comb begin
        w_mux = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_way_data[w] = w_bank_rd[w];
            if (r_byp_valid && r_byp_way[w]) begin
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (r_byp_be[b]) begin
                        w_way_data[w][b*BYTE_SIZE +: BYTE_SIZE] = r_byp_data[b*BYTE_SIZE +: BYTE_SIZE];
                    end
                end
            end
            if (i_rd_sel[w]) begin
                w_mux = w_mux | w_way_data[w];
            end
        end
    end

    if (OUTPUT_REG != 0) begin : g_oreg
        logic                  r_out_valid;
        logic [DATA_WIDTH-1:0] r_out_data;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
            end else begin
                r_out_valid <= r_rd_pend;
                if (r_rd_pend) begin
                    r_out_data <= w_mux;
                end
            end
        end

        assign o_rd_valid = r_out_valid;
        assign o_rd_data  = r_out_data;
    end else begin : g_ocomb
        logic [DATA_WIDTH-1:0] r_hold;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_hold <= '0;
            end else if (r_rd_pend) begin
                r_hold <= w_mux;
            end
        end

        assign o_rd_valid = r_rd_pend;
        assign o_rd_data  = r_rd_pend ? w_mux : r_hold;
    end

endmodule

// File: tb/tb_dcache_data_array.sv
// Randomised + directed bench for dcache_data_array, driving one instance of each
// output-register option with identical stimulus and scoreboarding both.
module tb_dcache_data_array;

    localparam int WAYS  = 4;
    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int BS    = 8;
    localparam int BEW   = DW / BS;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            wr_en = 1'b0, rd_en = 1'b0;
    logic [WAYS-1:0] wr_way = '0, rd_sel = '0;
    logic [AW-1:0]   wr_addr = '0, rd_addr = '0;
    logic [BEW-1:0]  wr_be = '0;
    logic [DW-1:0]   wr_data = '0;

    logic            busy0, busy1, val0, val1;
    logic [DW-1:0]   data0, data1;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mdl_mem [WAYS][DEPTH];
    logic [DW-1:0] snap [WAYS];
    bit            m_busy = 1'b1;
    int            m_cnt  = 0;
    bit            m_pend = 1'b0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] last0 = '0, last1 = '0;
    logic          rst_d = 1'b0;

    dcache_data_array #(
        .WAYS(WAYS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(BS), .OUTPUT_REG(0)
    ) u_dut0 (
        .i_clk(clk), .i_rst(rst), .o_init_busy(busy0),
        .i_wr_en(wr_en), .i_wr_way(wr_way), .i_wr_addr(wr_addr),
        .i_wr_byte_en(wr_be), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_rd_sel(rd_sel),
        .o_rd_valid(val0), .o_rd_data(data0)
    );

    dcache_data_array #(
        .WAYS(WAYS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(BS), .OUTPUT_REG(1)
    ) u_dut1 (
        .i_clk(clk), .i_rst(rst), .o_init_busy(busy1),
        .i_wr_en(wr_en), .i_wr_way(wr_way), .i_wr_addr(wr_addr),
        .i_wr_byte_en(wr_be), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_rd_sel(rd_sel),
        .o_rd_valid(val1), .o_rd_data(data1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BEW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BEW; b++)
            if (be[b]) r[b*BS +: BS] = nw[b*BS +: BS];
        return r;
    endfunction

    // Model applies the currently driven inputs at the coming edge, then checks init_busy.
    task automatic tick();
        logic [DW-1:0] e;
        if (m_pend) begin
            e = '0;
            for (int w = 0; w < WAYS; w++)
                if (rd_sel[w]) e = e | snap[w];
            q0.push_back(e);
            if (!rst) q1.push_back(e);
        end
        if (rst) begin
            for (int w = 0; w < WAYS; w++)
                for (int a = 0; a < DEPTH; a++) mdl_mem[w][a] = '0;
            m_busy = 1'b1;
            m_cnt  = 0;
            m_pend = 1'b0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == DEPTH) m_busy = 1'b0;
            m_pend = 1'b0;
        end else begin
            m_pend = rd_en;
            if (rd_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    snap[w] = mdl_mem[w][rd_addr];
                    if (wr_en && wr_way[w] && wr_addr == rd_addr)
                        snap[w] = merge(snap[w], wr_data, wr_be);
                end
            end
            if (wr_en)
                for (int w = 0; w < WAYS; w++)
                    if (wr_way[w]) mdl_mem[w][wr_addr] = merge(mdl_mem[w][wr_addr], wr_data, wr_be);
        end
        @(posedge clk);
        #1;
        check("init_busy0", 32'(busy0), 32'(m_busy));
        check("init_busy1", 32'(busy1), 32'(m_busy));
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; rd_sel = '0; wr_way = '0; wr_be = '0;
    endtask

    task automatic do_write(input logic [WAYS-1:0] way, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [BEW-1:0] be);
        wr_en = 1'b1; wr_way = way; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        idle();
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [WAYS-1:0] sel);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0; rd_sel = sel;
        tick();
        rd_sel = '0;
    endtask

    task automatic wait_ready();
        while (m_busy) tick();
    endtask

    always @(posedge clk) rst_d <= rst;

    // Monitor: pops expected data on each rd_valid, otherwise checks rd_data holds.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_d) begin
                last0 = '0;
                last1 = '0;
            end
            if (val0) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_valid0 actual=1 required=0 at %0t", $time);
                end else begin
                    e = q0.pop_front();
                    check("rd_data0", data0, e);
                    last0 = e;
                end
            end else begin
                check("rd_hold0", data0, last0);
            end
            if (val1) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_valid1 actual=1 required=0 at %0t", $time);
                end else begin
                    e = q1.pop_front();
                    check("rd_data1", data1, e);
                    last1 = e;
                end
            end else begin
                check("rd_hold1", data1, last1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] probe [3];
        probe[0] = AW'(0); probe[1] = AW'(255); probe[2] = AW'(511);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Accesses attempted while clearing must be ignored.
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_way = '1; wr_be = '1; wr_data = 32'hDEADBEEF;
            wr_addr = AW'(i); rd_en = 1'b1; rd_addr = AW'(i); rd_sel = '1;
            tick();
        end
        idle();
        wait_ready();

        for (int p = 0; p < 3; p++)
            for (int k = 0; k < WAYS; k++)
                do_read(probe[p], WAYS'(1 << k));

        do_write(4'b0100, AW'(5), 32'hAABBCCDD, 4'b1111);
        do_write(4'b0100, AW'(5), 32'h11223344, 4'b0101);
        do_read(AW'(5), 4'b0100);

        for (int k = 0; k < WAYS; k++)
            do_write(WAYS'(1 << k), AW'(16), DW'(k), 4'b1111);
        do_read(AW'(16), 4'b1000);
        do_read(AW'(16), 4'b0000);
        do_read(AW'(16), 4'b0110);

        do_write(4'b0010, AW'(32), 32'h12345678, 4'b1111);
        wr_en = 1'b1; wr_way = 4'b0010; wr_addr = AW'(32); wr_data = 32'hFFFF0000; wr_be = 4'b1100;
        rd_en = 1'b1; rd_addr = AW'(32);
        tick();
        idle();
        rd_sel = 4'b0010;
        tick();
        rd_sel = '0;
        do_read(AW'(32), 4'b0010);

        for (int i = 0; i < 1500; i++) begin
            rd_sel  = WAYS'($urandom_range(0, 15));
            wr_en   = 1'($urandom_range(0, 1));
            wr_way  = WAYS'($urandom_range(0, 15));
            wr_addr = AW'(64 + $urandom_range(0, 3));
            wr_be   = BEW'($urandom_range(0, 15));
            wr_data = $urandom;
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = AW'(64 + $urandom_range(0, 3));
            tick();
        end
        idle();
        tick();

        // Reset while a read is in flight, and a read issued together with reset.
        rd_en = 1'b1; rd_addr = AW'(5);
        tick();
        rd_en = 1'b1; rd_sel = 4'b0100; rst = 1'b1;
        tick();
        rst = 1'b0; idle();
        wait_ready();
        do_read(AW'(5), 4'b0100);
        do_read(AW'(32), 4'b0010);

        // Reset in the middle of clearing restarts the full sequence.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (300) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready();
        do_read(AW'(16), 4'b1111);

        idle();
        repeat (4) tick();
        check("q0_drain", 32'(q0.size()), 32'd0);
        check("q1_drain", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
